// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: access size codes, FSM states and
// small helpers for address-offset handling.
package lsu_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RD   = 2'b01,
        WR   = 2'b10,
        RESP = 2'b11
    } state_e;

    // True when the byte offset is not naturally aligned for the access size.
    function automatic logic misaligned(input size_e size, input logic [1:0] off);
        case (size)
            SZ_HALF: misaligned = off[0];
            SZ_WORD: misaligned = |off;
            default: misaligned = 1'b0;
        endcase
    endfunction

    // Lane offset actually used: halves use addr[1] only, words always lane 0.
    function automatic logic [1:0] eff_offset(input size_e size, input logic [1:0] off);
        case (size)
            SZ_HALF: eff_offset = {off[1], 1'b0};
            SZ_WORD: eff_offset = 2'b00;
            default: eff_offset = off;
        endcase
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane steering for the load/store unit: extracts and extends a
// sub-word load from a memory word, and merges sub-word store data into the
// word read back from memory (little-endian byte lanes).
module lsu_lane_align
    import lsu_pkg::*;
(
    input  size_e       size,
    input  logic [1:0]  offset,
    input  logic        sign_ext,
    input  logic [31:0] rdata,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merged
);

    logic [4:0]  shamt;
    logic [31:0] shifted;
    logic [31:0] lane_mask;

    assign shamt = {offset, 3'b000};

    // Load path: shift the addressed lane down to bit 0, then zero/sign extend.
    always_comb begin
        shifted   = rdata >> shamt;
        load_data = shifted;
        case (size)
            SZ_BYTE: load_data = {{24{sign_ext & shifted[7]}}, shifted[7:0]};
            SZ_HALF: load_data = {{16{sign_ext & shifted[15]}}, shifted[15:0]};
            default: load_data = shifted;
        endcase
    end

    // Store path: replace only the target lane(s), keep the other bytes.
    always_comb begin
        lane_mask = 32'hFFFF_FFFF;
        case (size)
            SZ_BYTE: lane_mask = 32'h0000_00FF << shamt;
            SZ_HALF: lane_mask = 32'h0000_FFFF << shamt;
            default: lane_mask = 32'hFFFF_FFFF;
        endcase
        merged = (rdata & ~lane_mask) | ((wdata << shamt) & lane_mask);
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: turns byte/half/word CPU requests into word-aligned memory
// accesses, doing read-modify-write for sub-word stores.
// Optional build macro LSU_ALIGN_CHECK_EN: when defined, misaligned half/word
// requests fail immediately without touching memory; otherwise the offending
// low address bits are ignored and the access proceeds.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int RD_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_error,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_error
);

    localparam int CW = $clog2(RD_LAT + 1);
    localparam logic [CW-1:0] CNT_INIT = CW'(RD_LAT - 1);

    state_e      state;
    logic [CW-1:0] cnt;
    logic        st_store;
    size_e       st_size;
    logic        st_signed;
    logic [1:0]  st_off;
    logic [31:0] st_wdata;

    size_e       in_size;
    logic [1:0]  in_off;
    logic        acc_err;
    logic [31:0] load_data;
    logic [31:0] merged;

    assign in_size = size_e'(req_size);
    assign in_off  = eff_offset(in_size, req_addr[1:0]);

`ifdef LSU_ALIGN_CHECK_EN
    assign acc_err = (in_size == SZ_RSVD) || misaligned(in_size, req_addr[1:0]);
`else
    assign acc_err = (in_size == SZ_RSVD);
`endif

    lsu_lane_align u_lane_align (
        .size      (st_size),
        .offset    (st_off),
        .sign_ext  (st_signed),
        .rdata     (mem_rdata),
        .wdata     (st_wdata),
        .load_data (load_data),
        .merged    (merged)
    );

    // Request sequencing FSM with registered handshake, memory and response outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            st_store   <= 1'b0;
            st_size    <= SZ_BYTE;
            st_signed  <= 1'b0;
            st_off     <= 2'b00;
            st_wdata   <= 32'h0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_error <= 1'b0;
            resp_rdata <= 32'h0;
            mem_rd     <= 1'b0;
            mem_wr     <= 1'b0;
            mem_addr   <= 32'h0;
            mem_wdata  <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        st_store  <= req_store;
                        st_size   <= in_size;
                        st_signed <= req_signed;
                        st_off    <= in_off;
                        st_wdata  <= req_wdata;
                        req_ready <= 1'b0;
                        mem_addr  <= {req_addr[31:2], 2'b00};
                        if (acc_err) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_error <= 1'b1;
                            resp_rdata <= 32'h0;
                        end else if (req_store && in_size == SZ_WORD) begin
                            state     <= WR;
                            mem_wr    <= 1'b1;
                            mem_wdata <= req_wdata;
                        end else begin
                            state  <= RD;
                            mem_rd <= 1'b1;
                            cnt    <= CNT_INIT;
                        end
                    end
                end
                RD: begin
                    if (cnt == '0) begin
                        mem_rd <= 1'b0;
                        if (!st_store) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_error <= mem_error;
                            resp_rdata <= mem_error ? 32'h0 : load_data;
                        end else if (mem_error) begin
                            // Read half of a read-modify-write failed: never write.
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_error <= 1'b1;
                            resp_rdata <= 32'h0;
                        end else begin
                            state     <= WR;
                            mem_wr    <= 1'b1;
                            mem_wdata <= merged;
                        end
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                WR: begin
                    mem_wr     <= 1'b0;
                    state      <= RESP;
                    resp_valid <= 1'b1;
                    resp_error <= mem_error;
                    resp_rdata <= 32'h0;
                end
                RESP: begin
                    resp_valid <= 1'b0;
                    resp_error <= 1'b0;
                    resp_rdata <= 32'h0;
                    req_ready  <= 1'b1;
                    state      <= IDLE;
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                    mem_rd    <= 1'b0;
                    mem_wr    <= 1'b0;
                end
            endcase
        end
    end

endmodule
